// File: rtl/qracc_window_sequencer.sv
// Convolution-window sequencer for the QRAcc datapath.
// Walks output pixels (stride, zero padding, output-channel passes), issues
// one ifmap row request per filter row, hands a complete window to the MAC
// array and independently produces ofmap writeback addresses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, all counters zero
// S_FETCH | issuing row reads for the current pixel, fy = filter row
// S_WIN   | window complete, waiting for the MAC to accept it
// S_DRAIN | all windows issued, waiting for the remaining writebacks
// S_DONE  | one-cycle completion pulse, counters cleared on exit
module qracc_window_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16,
    parameter int FY_W   = 4,
    parameter int PAD_W  = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              clear,
    input  logic [DIM_W-1:0]  cfg_ifmap_w,
    input  logic [DIM_W-1:0]  cfg_ifmap_h,
    input  logic [DIM_W-1:0]  cfg_ofmap_w,
    input  logic [DIM_W-1:0]  cfg_ofmap_h,
    input  logic [DIM_W-1:0]  cfg_channels,
    input  logic [FY_W-1:0]   cfg_fy,
    input  logic [PAD_W-1:0]  cfg_stride,
    input  logic [PAD_W-1:0]  cfg_pad,
    input  logic [DIM_W-1:0]  cfg_n_passes,
    input  logic [ADDR_W-1:0] cfg_ifmap_base,
    input  logic [ADDR_W-1:0] cfg_ofmap_base,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [FY_W-1:0]   rd_fy,
    output logic              rd_pad_row,
    output logic [PAD_W-1:0]  rd_lpad,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_last,
    input  logic              mac_out_valid,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DIM_W-1:0]  pass_idx,
    output logic              busy,
    output logic              done
);

    // signed input coordinates carry two guard bits so negative (padded)
    // positions and positions past the fmap edge are both representable
    localparam int SW = DIM_W + 2;
    localparam int MW = DIM_W + PAD_W;
    localparam int PW = 2 * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WIN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0] ox, oy, pass_cnt;
    logic [FY_W-1:0]  fy;
    logic [PW-1:0]    wb_pix;
    logic [DIM_W-1:0] wb_pass;
    logic             busy_q, done_q, rd_valid_q, win_valid_q;

    logic rd_fire, win_fire;
    logic fy_last, ox_last, oy_last, pass_last;
    logic [PW-1:0] n_pix;
    logic wb_pix_last, wb_complete_nxt;

    // handshakes and wrap conditions of the walking counters
    always_comb begin
        rd_fire   = rd_valid_q && rd_ready;
        win_fire  = win_valid_q && win_ready;
        fy_last   = (fy == cfg_fy - FY_W'(1));
        ox_last   = (ox == cfg_ofmap_w - DIM_W'(1));
        oy_last   = (oy == cfg_ofmap_h - DIM_W'(1));
        pass_last = (pass_cnt == cfg_n_passes - DIM_W'(1));
        n_pix     = PW'(cfg_ofmap_w) * PW'(cfg_ofmap_h);
        wb_en     = mac_out_valid && busy_q;
        wb_pix_last = (wb_pix == n_pix - PW'(1));
        // looks one writeback ahead so done follows the final write directly
        wb_complete_nxt = (wb_pass == cfg_n_passes) ||
                          (wb_en && wb_pix_last && (wb_pass == cfg_n_passes - DIM_W'(1)));
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (rd_fire && fy_last) state_nxt = S_WIN;
            S_WIN: begin
                if (win_fire) begin
                    if (ox_last && oy_last && pass_last) state_nxt = S_DRAIN;
                    else                                 state_nxt = S_FETCH;
                end
            end
            S_DRAIN: if (wb_complete_nxt) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state, registered status flags and all sequencing counters
    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            win_valid_q <= 1'b0;
            ox          <= '0;
            oy          <= '0;
            pass_cnt    <= '0;
            fy          <= '0;
            wb_pix      <= '0;
            wb_pass     <= '0;
        end else begin
            state       <= state_nxt;
            busy_q      <= (state_nxt != S_IDLE);
            done_q      <= (state_nxt == S_DONE);
            rd_valid_q  <= (state_nxt == S_FETCH);
            win_valid_q <= (state_nxt == S_WIN);

            if (rd_fire) fy <= fy_last ? '0 : fy + FY_W'(1);

            if (win_fire) begin
                if (!ox_last) begin
                    ox <= ox + DIM_W'(1);
                end else begin
                    ox <= '0;
                    if (!oy_last) begin
                        oy <= oy + DIM_W'(1);
                    end else begin
                        oy <= '0;
                        // the final pass index stays visible through drain
                        if (!pass_last) pass_cnt <= pass_cnt + DIM_W'(1);
                    end
                end
            end

            if (wb_en) begin
                if (wb_pix_last) begin
                    wb_pix  <= '0;
                    wb_pass <= wb_pass + DIM_W'(1);
                end else begin
                    wb_pix <= wb_pix + PW'(1);
                end
            end

            if (state == S_DONE) begin
                ox       <= '0;
                oy       <= '0;
                pass_cnt <= '0;
                fy       <= '0;
                wb_pix   <= '0;
                wb_pass  <= '0;
            end
        end
    end

    logic [MW-1:0]        ox_mul, oy_mul;
    logic signed [SW-1:0] ix, iy, ix_neg;
    logic [SW-1:0]        ix_pos;
    logic                 pad_row;
    logic [ADDR_W-1:0]    row_off;

    // row request geometry for the current pixel and filter row
    always_comb begin
        ox_mul  = MW'(ox) * MW'(cfg_stride);
        oy_mul  = MW'(oy) * MW'(cfg_stride);
        ix      = $signed(ox_mul[SW-1:0]) - $signed(SW'(cfg_pad));
        iy      = $signed(oy_mul[SW-1:0]) - $signed(SW'(cfg_pad)) + $signed(SW'(fy));
        ix_neg  = -ix;
        ix_pos  = ix[SW-1] ? '0 : ix;
        pad_row = iy[SW-1] || (iy >= $signed(SW'(cfg_ifmap_h)));
        row_off = ADDR_W'(cfg_channels) *
                  (ADDR_W'(ix_pos) + ADDR_W'(cfg_ifmap_w) * ADDR_W'(iy));

        rd_valid   = rd_valid_q;
        rd_fy      = rd_valid_q ? fy : '0;
        rd_pad_row = rd_valid_q && pad_row;
        rd_addr    = (rd_valid_q && !pad_row) ? cfg_ifmap_base + row_off : '0;
        rd_lpad    = (rd_valid_q && !pad_row && ix[SW-1]) ? ix_neg[PAD_W-1:0] : '0;
    end

    // window, writeback and status outputs
    always_comb begin
        win_valid = win_valid_q;
        win_last  = win_valid_q && ox_last && oy_last;
        pass_idx  = pass_cnt;
        busy      = busy_q;
        done      = done_q;
        wb_addr   = busy_q ? cfg_ofmap_base + ADDR_W'(wb_pix) * ADDR_W'(cfg_n_passes)
                             + ADDR_W'(wb_pass)
                           : '0;
    end

endmodule

// File: tb/tb_qracc_window_sequencer.sv
// Randomized bench for qracc_window_sequencer against a loop-nest model of
// the expected row requests, windows and writeback addresses.
module tb_qracc_window_sequencer;

    logic        clk = 1'b0;
    logic        nrst, start, clear;
    logic [15:0] cfg_ifmap_w, cfg_ifmap_h, cfg_ofmap_w, cfg_ofmap_h;
    logic [15:0] cfg_channels, cfg_n_passes;
    logic [3:0]  cfg_fy, cfg_stride, cfg_pad;
    logic [31:0] cfg_ifmap_base, cfg_ofmap_base;
    logic        rd_valid, rd_ready, rd_pad_row;
    logic [31:0] rd_addr, wb_addr;
    logic [3:0]  rd_fy, rd_lpad;
    logic        win_valid, win_ready, win_last, mac_out_valid, wb_en, busy, done;
    logic [15:0] pass_idx;

    always #5 clk = ~clk;

    qracc_window_sequencer dut (
        .clk(clk), .nrst(nrst), .start(start), .clear(clear),
        .cfg_ifmap_w(cfg_ifmap_w), .cfg_ifmap_h(cfg_ifmap_h),
        .cfg_ofmap_w(cfg_ofmap_w), .cfg_ofmap_h(cfg_ofmap_h),
        .cfg_channels(cfg_channels), .cfg_fy(cfg_fy), .cfg_stride(cfg_stride),
        .cfg_pad(cfg_pad), .cfg_n_passes(cfg_n_passes),
        .cfg_ifmap_base(cfg_ifmap_base), .cfg_ofmap_base(cfg_ofmap_base),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_fy(rd_fy),
        .rd_pad_row(rd_pad_row), .rd_lpad(rd_lpad),
        .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last),
        .mac_out_valid(mac_out_valid), .wb_en(wb_en), .wb_addr(wb_addr),
        .pass_idx(pass_idx), .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          fy;
        bit          pad;
        int          lpad;
    } rd_t;
    typedef struct {
        bit last;
        int pass;
    } win_t;

    rd_t         rq[$];
    win_t        wq[$];
    logic [31:0] bq[$];

    int W, H, C, FY, S, P, OW, OH, NP;
    logic [31:0] IB, OB;

    task automatic set_cfg(input int w, h, c, f, s, p, ow, oh, np,
                           input logic [31:0] ib, ob);
        W = w; H = h; C = c; FY = f; S = s; P = p; OW = ow; OH = oh; NP = np;
        IB = ib; OB = ob;
        cfg_ifmap_w = 16'(w);  cfg_ifmap_h = 16'(h);
        cfg_ofmap_w = 16'(ow); cfg_ofmap_h = 16'(oh);
        cfg_channels = 16'(c); cfg_n_passes = 16'(np);
        cfg_fy = 4'(f); cfg_stride = 4'(s); cfg_pad = 4'(p);
        cfg_ifmap_base = ib; cfg_ofmap_base = ob;
    endtask

    // expected traffic straight from the convolution geometry
    task automatic build_model();
        rd_t  r;
        win_t wv;
        rq.delete(); wq.delete(); bq.delete();
        for (int ps = 0; ps < NP; ps++)
            for (int y = 0; y < OH; y++)
                for (int x = 0; x < OW; x++) begin
                    for (int f = 0; f < FY; f++) begin
                        int iy, ix, xc;
                        iy = y * S - P + f;
                        ix = x * S - P;
                        r.fy = f;
                        if (iy < 0 || iy >= H) begin
                            r.pad = 1; r.addr = 0; r.lpad = 0;
                        end else begin
                            xc = (ix < 0) ? 0 : ix;
                            r.pad  = 0;
                            r.addr = IB + 32'(C * (xc + W * iy));
                            r.lpad = (ix < 0) ? -ix : 0;
                        end
                        rq.push_back(r);
                    end
                    wv.last = (x == OW - 1) && (y == OH - 1);
                    wv.pass = ps;
                    wq.push_back(wv);
                end
        for (int ps = 0; ps < NP; ps++)
            for (int px = 0; px < OW * OH; px++)
                bq.push_back(OB + 32'(px * NP + ps));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_last"}, win_last, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_fy"}, rd_fy, 0);
        chk({tag, "_rd_pad_row"}, rd_pad_row, 0);
        chk({tag, "_rd_lpad"}, rd_lpad, 0);
        chk({tag, "_pass_idx"}, pass_idx, 0);
        chk({tag, "_wb_en"}, wb_en, 0);
        chk({tag, "_wb_addr"}, wb_addr, 0);
    endtask

    // abort: 0 full run, 1 clear while a window waits, 2 reset mid-fetch
    task automatic run_case(input int p_rd, p_win, p_mac, input bit stall, input int abort);
        int   total_wb, issued, t_last, u_last, done_cyc, stall_cnt, n_rd0, n_win0;
        bit   seen_done, stalled, prev_hold;
        logic [31:0] prev_addr;
        logic [3:0]  prev_fy;
        rd_t  e;
        win_t w;
        build_model();
        total_wb = OW * OH * NP;
        n_rd0 = rq.size(); n_win0 = wq.size();
        issued = 0; t_last = -100; u_last = -100; done_cyc = -1;
        stall_cnt = 0; seen_done = 0; stalled = 0; prev_hold = 0;
        prev_addr = 0; prev_fy = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            rd_ready = ($urandom % 100) < p_rd;
            if (stall && !stalled && win_valid) begin
                stalled = 1; stall_cnt = 5;
            end
            win_ready = (stall_cnt > 0) ? 1'b0 : (($urandom % 100) < p_win);
            mac_out_valid = (issued < total_wb) && (($urandom % 100) < p_mac);
            #1;
            if ((abort == 1 && win_valid && wq.size() < n_win0) ||
                (abort == 2 && rd_valid && rq.size() < n_rd0)) begin
                if (abort == 1) clear = 1'b1; else nrst = 1'b0;
                @(negedge clk);
                #1;
                check_idle(abort == 1 ? "clear" : "nrst");
                clear = 1'b0; nrst = 1'b1;
                rd_ready = 0; win_ready = 0; mac_out_valid = 0;
                return;
            end
            if (prev_hold) begin
                chk("rd_hold_valid", rd_valid, 1);
                chk("rd_hold_addr", rd_addr, prev_addr);
                chk("rd_hold_fy", rd_fy, prev_fy);
            end
            if (stall_cnt > 0) begin
                chk("stall_win_valid", win_valid, 1);
                chk("stall_rd_valid", rd_valid, 0);
                chk("stall_rd_addr", rd_addr, 0);
                stall_cnt--;
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("rd_addr", rd_addr, e.addr);
                    chk("rd_fy", rd_fy, e.fy);
                    chk("rd_pad_row", rd_pad_row, e.pad);
                    chk("rd_lpad", rd_lpad, e.lpad);
                end
            end
            if (win_valid && win_ready) begin
                if (wq.size() == 0) chk("win_extra", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("win_last", win_last, w.last);
                    chk("pass_idx", pass_idx, w.pass);
                    if (wq.size() == 0) t_last = cyc;
                end
            end
            if (wb_en) begin
                if (bq.size() == 0) chk("wb_extra", 1, 0);
                else chk("wb_addr", wb_addr, bq.pop_front());
                issued++;
                if (issued == total_wb) u_last = cyc;
            end
            if (done) begin
                chk("done_cycle", cyc, (t_last + 2 > u_last + 1) ? t_last + 2 : u_last + 1);
                chk("done_rd_left", rq.size(), 0);
                chk("done_win_left", wq.size(), 0);
                chk("done_wb_left", bq.size(), 0);
                seen_done = 1;
                done_cyc = cyc;
            end else if (seen_done && cyc == done_cyc + 1) begin
                chk("post_done_busy", busy, 0);
                chk("post_done_pulse", done, 0);
                break;
            end
            prev_hold = rd_valid && !rd_ready;
            prev_addr = rd_addr;
            prev_fy = rd_fy;
        end
        if (!seen_done) chk("timeout_done", 0, 1);
        start = 0; rd_ready = 0; win_ready = 0; mac_out_valid = 0;
    endtask

    initial begin
        nrst = 0; start = 0; clear = 0;
        rd_ready = 0; win_ready = 0; mac_out_valid = 0;
        set_cfg(4, 4, 1, 3, 1, 0, 2, 2, 1, 0, 0);
        repeat (3) @(negedge clk);
        mac_out_valid = 1;
        #1;
        check_idle("reset");
        mac_out_valid = 0;
        nrst = 1;
        @(negedge clk);

        run_case(100, 100, 50, 0, 0);
        set_cfg(4, 4, 1, 3, 1, 1, 4, 4, 1, 0, 0);
        run_case(100, 100, 60, 0, 0);
        set_cfg(5, 5, 2, 3, 2, 0, 2, 2, 1, 0, 0);
        run_case(100, 100, 60, 0, 0);
        set_cfg(4, 4, 1, 3, 1, 0, 2, 2, 1, 0, 0);
        run_case(50, 100, 40, 1, 0);
        set_cfg(4, 4, 1, 3, 1, 0, 2, 2, 2, 0, 100);
        run_case(80, 80, 50, 0, 0);
        set_cfg(4, 4, 1, 3, 1, 0, 2, 2, 1, 32'h40, 0);
        run_case(100, 50, 30, 0, 1);
        run_case(100, 100, 50, 0, 0);
        run_case(60, 100, 30, 0, 2);
        run_case(100, 100, 50, 0, 0);
        set_cfg(3, 3, 2, 1, 1, 0, 1, 1, 3, 32'h10, 32'h200);
        run_case(70, 70, 50, 0, 0);

        for (int k = 0; k < 12; k++) begin
            set_cfg($urandom_range(3, 8), $urandom_range(3, 8), $urandom_range(1, 4),
                    $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 2),
                    $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3),
                    $urandom, $urandom);
            run_case($urandom_range(30, 100), $urandom_range(30, 100),
                     $urandom_range(20, 90), k[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
